// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

  // One buffered multi-cycle result; live drops when a newer pipe write supersedes it.
  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Circular buffer of multi-cycle results with per-address kill and live-address decode.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  wb_entry_t                        push_entry_i,
  input  logic                             pop_i,
  input  logic                             kill_i,
  input  logic [WB_ADDR_W-1:0]             kill_addr_i,
  output wb_entry_t                        head_o,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic [(2**WB_ADDR_W)-1:0]        live_mask_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**WB_ADDR_W;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Kill matching entries, retire the popped slot, then write the pushed entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (kill_i && (mem_q[i].addr == kill_addr_i)) begin
        mem_d[i].live = 1'b0;
      end
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i) begin
      mem_d[head_q].live = 1'b0;
      head_d             = head_q + PTR_W'(1);
    end
    if (push_i) begin
      mem_d[tail_q] = push_entry_i;
      tail_d        = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Buffer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // OR-decode of live entries; popped and killed slots carry live=0.
  always_comb begin
    live_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].live) begin
        live_mask_o[mem_q[i].addr] = 1'b1;
      end
    end
    live_mask_o[0] = 1'b0;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  logic unused_nreg;
  assign unused_nreg = ^NREG'(0);

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port producer: pipe writes first, buffered multi-cycle results in free slots.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pipe_we_i,
  input  logic [ADDR_W-1:0]          pipe_addr_i,
  input  logic [DATA_W-1:0]          pipe_data_i,
  input  logic                       mc_valid_i,
  input  logic [ADDR_W-1:0]          mc_addr_i,
  input  logic [DATA_W-1:0]          mc_data_i,
  output logic                       mc_ready_o,
  output logic [ADDR_W-1:0]          RDaddr_o,
  output logic [DATA_W-1:0]          RDdata_o,
  output logic                       RegWrite_o,
  output logic [(2**ADDR_W)-1:0]     pending_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned NREG  = 2**ADDR_W;

  logic                        pipe_issue;
  logic                        mc_accept;
  logic                        mc_store;
  logic                        pop;
  wb_entry_t                   push_entry;
  wb_entry_t                   head;
  logic [CNT_W-1:0]            fifo_count;
  logic [(2**WB_ADDR_W)-1:0]   live_mask;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Writes to the zero register are dropped; a same-edge pipe write supersedes a matching mc result.
  assign pipe_issue = pipe_we_i && (WB_ADDR_W'(pipe_addr_i) != ZERO_REG);
  assign mc_ready_o = fifo_count < CNT_W'(DEPTH);
  assign mc_accept  = mc_valid_i && mc_ready_o;
  assign mc_store   = mc_accept && (WB_ADDR_W'(mc_addr_i) != ZERO_REG) &&
                      !(pipe_issue && (mc_addr_i == pipe_addr_i));

  assign push_entry.live = 1'b1;
  assign push_entry.addr = WB_ADDR_W'(mc_addr_i);
  assign push_entry.data = WB_DATA_W'(mc_data_i);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (mc_store),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (pipe_issue),
    .kill_addr_i  (WB_ADDR_W'(pipe_addr_i)),
    .head_o       (head),
    .count_o      (fifo_count),
    .live_mask_o  (live_mask)
  );

  // Issue priority: pipe write, else FIFO head (killed heads pop silently), else idle.
  always_comb begin
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    pop         = 1'b0;
    if (pipe_issue) begin
      reg_write_d = 1'b1;
      rd_addr_d   = pipe_addr_i;
      rd_data_d   = pipe_data_i;
    end else if (fifo_count != '0) begin
      pop         = 1'b1;
      reg_write_d = head.live;
      rd_addr_d   = ADDR_W'(head.addr);
      rd_data_d   = DATA_W'(head.data);
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign RegWrite_o = reg_write_q;
  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;
  assign pending_o  = NREG'(live_mask);
  assign count_o    = fifo_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
module tb_wb_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        mc_valid_i;
  logic [4:0]  mc_addr_i;
  logic [31:0] mc_data_i;
  logic        mc_ready_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;
  logic [31:0] pending_o;
  logic [2:0]  count_o;

  int checks   = 0;
  int failures = 0;
  int zero_wr  = 0;

  wb_write_arbiter #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pipe_we_i   (pipe_we_i),
    .pipe_addr_i (pipe_addr_i),
    .pipe_data_i (pipe_data_i),
    .mc_valid_i  (mc_valid_i),
    .mc_addr_i   (mc_addr_i),
    .mc_data_i   (mc_data_i),
    .mc_ready_o  (mc_ready_o),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o),
    .RegWrite_o  (RegWrite_o),
    .pending_o   (pending_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (RegWrite_o === 1'b1 && RDaddr_o === 5'd0) zero_wr++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    pipe_we_i   = 1'b0;
    pipe_addr_i = '0;
    pipe_data_i = '0;
    mc_valid_i  = 1'b0;
    mc_addr_i   = '0;
    mc_data_i   = '0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_we_i = 1'b1; pipe_addr_i = a; pipe_data_i = d;
  endtask

  task automatic mc(input logic [4:0] a, input logic [31:0] d);
    mc_valid_i = 1'b1; mc_addr_i = a; mc_data_i = d;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    check("rst_we",    64'(RegWrite_o), 64'd0);
    check("rst_addr",  64'(RDaddr_o),   64'd0);
    check("rst_data",  64'(RDdata_o),   64'd0);
    check("rst_count", 64'(count_o),    64'd0);
    check("rst_pend",  64'(pending_o),  64'd0);
    check("rst_ready", 64'(mc_ready_o), 64'd1);

    // Pipe write with empty FIFO
    pipe(5'd5, 32'hDEADBEEF);
    tick();
    check("pw_we",    64'(RegWrite_o), 64'd1);
    check("pw_addr",  64'(RDaddr_o),   64'd5);
    check("pw_data",  64'(RDdata_o),   64'hDEADBEEF);
    check("pw_count", 64'(count_o),    64'd0);
    idle();
    tick();
    check("idle_we",   64'(RegWrite_o), 64'd0);
    check("idle_hold", 64'(RDaddr_o),   64'd5);

    // Single mc result: buffered one cycle, then written
    mc(5'd8, 32'h12);
    tick();
    idle();
    check("mc_pend",  64'(pending_o),  64'h100);
    check("mc_count", 64'(count_o),    64'd1);
    check("mc_nobyp", 64'(RegWrite_o), 64'd0);
    tick();
    check("mc_we",    64'(RegWrite_o), 64'd1);
    check("mc_addr",  64'(RDaddr_o),   64'd8);
    check("mc_data",  64'(RDdata_o),   64'h12);
    check("mc_pend0", 64'(pending_o),  64'd0);
    check("mc_cnt0",  64'(count_o),    64'd0);

    // Fill under continuous pipe writes
    for (int i = 0; i < 4; i++) begin
      pipe(5'd1, 32'h100 + 32'(i));
      mc(5'(10 + i), 32'h20 + 32'(i));
      tick();
      check("fill_addr", 64'(RDaddr_o), 64'd1);
    end
    check("full_cnt",   64'(count_o),    64'd4);
    check("full_ready", 64'(mc_ready_o), 64'd0);
    check("full_pend",  64'(pending_o),  64'h3C00);
    mc(5'd14, 32'h99);
    tick();
    check("full_hold", 64'(count_o), 64'd4);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_we",   64'(RegWrite_o), 64'd1);
      check("drain_addr", 64'(RDaddr_o),   64'(10 + i));
      check("drain_data", 64'(RDdata_o),   64'(32'h20 + 32'(i)));
      check("drain_rdy",  64'(mc_ready_o), 64'd1);
    end
    tick();
    check("drain_end", 64'(RegWrite_o), 64'd0);
    check("drain_cnt", 64'(count_o),    64'd0);

    // Kill of a buffered entry
    mc(5'd9, 32'hAA);
    tick();
    idle();
    check("kill_pend1", 64'(pending_o), 64'h200);
    pipe(5'd9, 32'hBB);
    tick();
    idle();
    check("kill_data",  64'(RDdata_o),  64'hBB);
    check("kill_pend0", 64'(pending_o), 64'd0);
    check("kill_cnt",   64'(count_o),   64'd1);
    tick();
    check("kill_pop_we", 64'(RegWrite_o), 64'd0);
    check("kill_pop_c",  64'(count_o),    64'd0);

    // Same-edge kill: mc entry accepted but not stored
    pipe(5'd7, 32'h77);
    mc(5'd7, 32'h70);
    tick();
    idle();
    check("same_data", 64'(RDdata_o), 64'h77);
    check("same_cnt",  64'(count_o),  64'd0);
    check("same_pend", 64'(pending_o), 64'd0);

    // Zero register handling
    mc(5'd0, 32'h44);
    tick();
    check("z_mc_cnt", 64'(count_o), 64'd0);
    mc(5'd3, 32'h33);
    tick();
    idle();
    check("z_enq_cnt", 64'(count_o), 64'd1);
    pipe(5'd0, 32'h55);
    tick();
    idle();
    check("z_drain_we",   64'(RegWrite_o), 64'd1);
    check("z_drain_addr", 64'(RDaddr_o),   64'd3);
    check("z_drain_data", 64'(RDdata_o),   64'h33);
    check("z_drain_cnt",  64'(count_o),    64'd0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      pipe(5'd2, 32'h200 + 32'(i));
      mc(5'(20 + i), 32'h40 + 32'(i));
      tick();
    end
    check("pre_rst_cnt", 64'(count_o), 64'd3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle();
    check("mrst_cnt",   64'(count_o),    64'd0);
    check("mrst_pend",  64'(pending_o),  64'd0);
    check("mrst_we",    64'(RegWrite_o), 64'd0);
    check("mrst_ready", 64'(mc_ready_o), 64'd1);
    tick();
    check("mrst_idle", 64'(RegWrite_o), 64'd0);

    check("zero_reg_write", 64'(zero_wr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Producer side of the register-file write port. Drives the regfile's RDaddr/RDdata/RegWrite inputs. Merges the in-order MEM/WB pipeline write with out-of-order results from the multi-cycle (mult/div) unit.
- Multi-cycle results are buffered in a small FIFO and written back in free slots, at most one regfile write per cycle.
- Exports a per-register pending vector so the hazard unit can stall readers of registers with buffered writes.

Parameters:
- DEPTH, 4, FIFO entries for multi-cycle results (power of 2, ≥2).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- pipe_we_i  in  1  MEM/WB write enable; always accepted, no backpressure.
- pipe_addr_i  in  ADDR_W  MEM/WB destination register.
- pipe_data_i  in  DATA_W  MEM/WB write data.
- mc_valid_i  in  1  multi-cycle result valid.
- mc_addr_i  in  ADDR_W  multi-cycle destination register.
- mc_data_i  in  DATA_W  multi-cycle result data.
- mc_ready_o  out  1  FIFO can accept; equals (count < DEPTH), from registered count only.
- RDaddr_o  out  ADDR_W  to regfile write address.
- RDdata_o  out  DATA_W  to regfile write data.
- RegWrite_o  out  1  to regfile write enable.
- pending_o  out  2**ADDR_W  bit r=1 iff a live FIFO entry targets register r.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy, live and killed entries.

Behaviour:
- Reset (rst_i=1 at an edge):
  - RegWrite_o=0, RDaddr_o=0, RDdata_o=0.
  - FIFO emptied, count_o=0, pending_o=0, mc_ready_o=1.
  - Any in-flight handshake that cycle is discarded.
- Outputs RDaddr_o/RDdata_o/RegWrite_o are registered; one write issued per edge at most.
- Issue priority, evaluated at each edge:
  - (1) pipe_we_i=1 and pipe_addr_i≠0: issue the pipe write.
  - (2) else, FIFO non-empty: pop head. Issue with RegWrite_o=1 if the head is live; with RegWrite_o=0 if killed. A killed pop still consumes the slot.
  - (3) else RegWrite_o=0. RDaddr_o/RDdata_o hold their last values.
- Latency:
  - Pipe write sampled at edge E: visible on outputs after E.
  - mc entry accepted at edge E: earliest visible after edge E+1. No bypass of an empty FIFO.
- Enqueue:
  - At an edge with mc_valid_i && mc_ready_o, the entry is accepted.
  - It is stored at the tail as live if mc_addr_i≠0.
  - mc_addr_i=0 is accepted but not stored (no count change).
- Kill rule: the pipe write is program-order newer than all buffered results. When a pipe write to addr X≠0 issues at edge E:
  - every stored entry with addr X is marked killed;
  - a same-edge mc entry with addr X is accepted but not stored.
- pipe_we_i with addr 0: ignored entirely. No issue, no kill; the FIFO may drain that cycle.
- Simultaneous enqueue and pop: both occur, count unchanged.
  - Full FIFO: mc_ready_o=0, so no enqueue.
- pending_o: combinational OR-decode of live entries' addresses. Bit 0 is always 0.
- Wrap-around: head and tail pointers are modulo DEPTH. An extra count bit distinguishes full from empty.
- Starvation: continuous pipe writes block draining. FIFO fills, mc_ready_o drops; this is allowed and relies on hazard-unit stalls.
- mc_* must be held stable while mc_valid_i=1 and mc_ready_o=0.

Decomposition:
- Package wb_pkg:
  - ADDR_W and DATA_W defaults.
  - Struct wb_entry_t {live, addr, data}.
  - Constant ZERO_REG=0.
- Sub-module wb_fifo: circular buffer of wb_entry_t with push/pop, per-address kill input, count and live-address outputs.
- The top level holds the issue-priority mux and output registers.

Test Plan:
- Reset mid-operation: enqueue 3 entries, assert rst_i for one edge → next cycle count_o=0, pending_o=0, RegWrite_o=0, mc_ready_o=1.
- Pipe write addr 5, data 0xDEADBEEF, with FIFO empty → RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF one edge later; count_o stays 0.
- Enqueue mc addr 8, data 0x12 at edge E with no pipe writes → pending_o[8]=1 after E; RegWrite_o=1, RDaddr_o=8 after E+1; pending_o=0 after E+1.
- Fill: 4 mc enqueues while pipe writes addr 1 every cycle → count_o=4, mc_ready_o=0. Pipe stops → 4 writes drained in FIFO order on consecutive cycles, mc_ready_o=1 after the first pop.
- Kill: enqueue mc addr 9 (0xAA), then pipe write addr 9 (0xBB) → regfile gets 0xBB. The later pop of entry 9 has RegWrite_o=0, and pending_o[9] clears at the kill edge.
- Zero register: mc addr 0 accepted with count_o unchanged; pipe addr 0 with a live FIFO head → head drains that cycle; RegWrite_o never asserted with RDaddr_o=0.
